// File: rtl/vend_credit_ctrl.sv
// Vending credit/dispense sequencer: coin accumulation, dispenser req/ack hand-off, change payout.
// Optional macro VEND_TIMEOUT_EN adds an auto-refund after TIMEOUT_CYC idle cycles in COLLECT.
module vend_credit_ctrl #(
    parameter int PRICE       = 15,
    parameter int MAX_CREDIT  = 45,
    parameter int CREDIT_W    = 6,
    parameter int TIMEOUT_CYC = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin_in,
    input  logic                cancel,
    input  logic                disp_ack,
    output logic                disp_req,
    output logic                chg_pulse,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic [1:0]          state_dbg
);
    // Handshake: disp_req rises on entry to VEND and stays high until the edge
    // that samples disp_ack high; that edge commits the purchase and drops disp_req.
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

    localparam logic [CREDIT_W:0] MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0] FIVE_W  = (CREDIT_W+1)'(5);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic                reject_d;
    logic                disp_req_d, chg_pulse_d, busy_d;
    logic                coin_valid;
    logic                tmo_hit;
    logic [CREDIT_W:0]   coin_val, sum_w, credit_w;

    assign coin_valid = (coin_in != 2'b00);
    assign credit_w   = {1'b0, credit};
    assign sum_w      = credit_w + coin_val;
    assign state_dbg  = state_q;

    always_comb begin
        coin_val = '0;
        case (coin_in)
            2'b01:   coin_val = (CREDIT_W+1)'(5);
            2'b10:   coin_val = (CREDIT_W+1)'(10);
            2'b11:   coin_val = (CREDIT_W+1)'(25);
            default: coin_val = '0;
        endcase
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state_q == S_COLLECT) && !coin_valid &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Counter is held at zero outside COLLECT, so entering COLLECT starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state_q != S_COLLECT || state_d != S_COLLECT || coin_valid)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            credit      <= '0;
            coin_reject <= 1'b0;
            disp_req    <= 1'b0;
            chg_pulse   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit      <= credit_d;
            coin_reject <= reject_d;
            disp_req    <= disp_req_d;
            chg_pulse   <= chg_pulse_d;
            busy        <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit;
        reject_d = 1'b0;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                // Cancel in IDLE has nothing to refund and is ignored.
                if (state_q == S_COLLECT && (cancel || tmo_hit)) begin
                    state_d  = S_CHANGE;
                    reject_d = coin_valid;
                end else if (coin_valid) begin
                    if (sum_w <= MAX_W) begin
                        credit_d = sum_w[CREDIT_W-1:0];
                        state_d  = (sum_w >= PRICE_W) ? S_VEND : S_COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                reject_d = coin_valid;
                if (disp_ack) begin
                    if (credit_w > PRICE_W) begin
                        credit_d = CREDIT_W'(credit_w - PRICE_W);
                        state_d  = S_CHANGE;
                    end else begin
                        credit_d = '0;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_CHANGE: begin
                reject_d = coin_valid;
                if (credit_w > FIVE_W) begin
                    credit_d = CREDIT_W'(credit_w - FIVE_W);
                end else begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_comb begin
        disp_req_d  = (state_d == S_VEND);
        chg_pulse_d = (state_d == S_CHANGE);
        busy_d      = (state_d == S_VEND) || (state_d == S_CHANGE);
    end
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: two instances (PRICE 15 and 45) against a credit/phase model.
module tb_vend_credit_ctrl;
    localparam int TMO = 8;
    localparam int PRICES [2] = '{15, 45};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] coin_in = 2'b00;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;

    logic       disp_req_w [2];
    logic       chg_pulse_w [2];
    logic       coin_reject_w [2];
    logic [5:0] credit_w [2];
    logic       busy_w [2];
    logic [1:0] state_w [2];

    int n_cmp = 0;
    int n_fail = 0;
    bit started = 1'b0;

    // Model: credit plus two flags; "collecting" is simply credit > 0 with neither flag set.
    int m_credit [2] = '{0, 0};
    bit m_vend [2] = '{0, 0};
    bit m_ref [2] = '{0, 0};
    bit m_rej [2] = '{0, 0};
    int m_idle [2] = '{0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vend_credit_ctrl #(.PRICE(PRICES[g]), .MAX_CREDIT(45), .CREDIT_W(6), .TIMEOUT_CYC(TMO)) dut (
            .clk(clk), .reset(reset), .coin_in(coin_in), .cancel(cancel), .disp_ack(disp_ack),
            .disp_req(disp_req_w[g]), .chg_pulse(chg_pulse_w[g]), .coin_reject(coin_reject_w[g]),
            .credit(credit_w[g]), .busy(busy_w[g]), .state_dbg(state_w[g])
        );
    end

    function automatic int coin_value(logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 25;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        int v;
        v = coin_value(coin_in);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_credit[k] = 0; m_vend[k] = 0; m_ref[k] = 0; m_rej[k] = 0; m_idle[k] = 0;
            end else begin
                m_rej[k] = 0;
                if (m_vend[k]) begin
                    m_rej[k] = (v != 0);
                    m_idle[k] = 0;
                    if (disp_ack) begin
                        m_credit[k] -= PRICES[k];
                        m_vend[k] = 0;
                        m_ref[k] = (m_credit[k] > 0);
                    end
                end else if (m_ref[k]) begin
                    m_rej[k] = (v != 0);
                    m_idle[k] = 0;
                    m_credit[k] -= 5;
                    if (m_credit[k] == 0) m_ref[k] = 0;
                end else if (cancel && m_credit[k] > 0) begin
                    m_ref[k] = 1;
                    m_rej[k] = (v != 0);
                    m_idle[k] = 0;
                end else if (v != 0) begin
                    m_idle[k] = 0;
                    if (m_credit[k] + v <= 45) begin
                        m_credit[k] += v;
                        if (m_credit[k] >= PRICES[k]) m_vend[k] = 1;
                    end else begin
                        m_rej[k] = 1;
                    end
                end else if (m_credit[k] > 0) begin
`ifdef VEND_TIMEOUT_EN
                    if (m_idle[k] == TMO - 1) begin
                        m_ref[k] = 1;
                        m_idle[k] = 0;
                    end else begin
                        m_idle[k]++;
                    end
`endif
                end else begin
                    m_idle[k] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("d%0d credit", k), int'(credit_w[k]), m_credit[k]);
                chk($sformatf("d%0d disp_req", k), int'(disp_req_w[k]), int'(m_vend[k]));
                chk($sformatf("d%0d chg_pulse", k), int'(chg_pulse_w[k]), int'(m_ref[k]));
                chk($sformatf("d%0d busy", k), int'(busy_w[k]), int'(m_vend[k] | m_ref[k]));
                chk($sformatf("d%0d coin_reject", k), int'(coin_reject_w[k]), int'(m_rej[k]));
            end
        end
    end

    // Apply one cycle of inputs; returns just after the edge that sampled them.
    task automatic drive(input logic [1:0] c, input logic ca, input logic a);
        coin_in = c; cancel = ca; disp_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        coin_in = 2'b00; cancel = 1'b0; disp_ack = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("reset credit", int'(credit_w[0]), 0);
        chk("reset disp_req", int'(disp_req_w[0]), 0);
        chk("reset chg_pulse", int'(chg_pulse_w[0]), 0);
        chk("reset busy", int'(busy_w[0]), 0);
        started = 1'b1;
        reset = 1'b0;

        // Exact purchase: 5 + 10 reaches 15, no change.
        drive(2'b01, 0, 0);
        chk("t1 credit 5", int'(credit_w[0]), 5);
        drive(2'b10, 0, 0);
        chk("t1 credit 15", int'(credit_w[0]), 15);
        chk("t1 disp_req", int'(disp_req_w[0]), 1);
        drive(2'b00, 0, 1);
        chk("t1 credit after ack", int'(credit_w[0]), 0);
        chk("t1 no chg", int'(chg_pulse_w[0]), 0);
        chk("t1 req dropped", int'(disp_req_w[0]), 0);

        // 25 coin: vend then two change coins.
        do_reset();
        drive(2'b11, 0, 0);
        chk("t2 disp_req", int'(disp_req_w[0]), 1);
        drive(2'b00, 0, 0);
        chk("t2 req held", int'(disp_req_w[0]), 1);
        drive(2'b00, 0, 1);
        chk("t2 credit after ack", int'(credit_w[0]), 10);
        chk("t2 chg 1", int'(chg_pulse_w[0]), 1);
        drive(2'b00, 0, 0);
        chk("t2 chg 2", int'(chg_pulse_w[0]), 1);
        drive(2'b00, 0, 0);
        chk("t2 chg done", int'(chg_pulse_w[0]), 0);
        chk("t2 credit 0", int'(credit_w[0]), 0);

        // Cancel refund; coin during refund is rejected, ack ignored.
        do_reset();
        drive(2'b10, 0, 0);
        drive(2'b00, 1, 0);
        chk("t3 chg on cancel", int'(chg_pulse_w[0]), 1);
        drive(2'b01, 0, 1);
        chk("t3 reject in change", int'(coin_reject_w[0]), 1);
        chk("t3 credit 5", int'(credit_w[0]), 5);
        drive(2'b00, 0, 0);
        chk("t3 credit 0", int'(credit_w[0]), 0);
        chk("t3 busy low", int'(busy_w[0]), 0);

        // PRICE=45 instance: overflow reject, then exact fill to MAX.
        do_reset();
        drive(2'b11, 0, 0);
        drive(2'b10, 0, 0);
        drive(2'b11, 0, 0);
        chk("t4 overflow reject", int'(coin_reject_w[1]), 1);
        chk("t4 credit held", int'(credit_w[1]), 35);
        drive(2'b10, 0, 0);
        chk("t4 credit max", int'(credit_w[1]), 45);
        chk("t4 disp_req", int'(disp_req_w[1]), 1);

        // Asynchronous reset in the middle of VEND.
        do_reset();
        drive(2'b11, 0, 0);
        chk("t5 in vend", int'(disp_req_w[0]), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("t5 req async", int'(disp_req_w[0]), 0);
        chk("t5 credit async", int'(credit_w[0]), 0);
        chk("t5 busy async", int'(busy_w[0]), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(2'b00, 0, 0);
        chk("t5 idle credit", int'(credit_w[0]), 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c;
            c = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            drive(c, ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0));
        end
`ifdef VEND_TIMEOUT_EN
        do_reset();
        drive(2'b01, 0, 0);
        repeat (TMO) drive(2'b00, 0, 0);
        chk("t6 timeout chg", int'(chg_pulse_w[0]), 1);
        drive(2'b00, 0, 0);
        chk("t6 timeout done", int'(credit_w[0]), 0);
`endif
        drive(2'b00, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
